// File: rtl/adc_conv_scheduler.sv
// Paced sample-request sequencer for one ADC measurement cycle: issues sample_req
// pulses, tracks sample/period indices, and flags completion, overruns and reader timeouts.
module adc_conv_scheduler #(
    parameter int SAMPLE_INTERVAL    = 1000,
    parameter int SAMPLES_PER_PERIOD = 32,
    parameter int PERIODS_PER_RESULT = 32,
    parameter int IDX_WIDTH          = 6,
    parameter int TIMER_WIDTH        = 16,
    parameter int TIMEOUT_CLKS       = 4000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 cycle_start,
    output logic                 sample_req,
    input  logic                 sample_done,
    output logic [IDX_WIDTH-1:0] sample_index,
    output logic [IDX_WIDTH-1:0] period_index,
    output logic                 period_first,
    output logic                 cycle_done,
    output logic                 active,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DONE,
        GAP,
        DONE
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] INTERVAL_LOAD = TIMER_WIDTH'(SAMPLE_INTERVAL - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE     = TIMER_WIDTH'(1);
    // The timeout counter starts one clock after sample_req, so it holds
    // TIMEOUT_CLKS-2 on the edge that completes TIMEOUT_CLKS clocks since the request.
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST  = TIMER_WIDTH'(TIMEOUT_CLKS - 2);
    localparam logic [IDX_WIDTH-1:0]   SAMPLE_LAST   = IDX_WIDTH'(SAMPLES_PER_PERIOD - 1);
    localparam logic [IDX_WIDTH-1:0]   PERIOD_LAST   = IDX_WIDTH'(PERIODS_PER_RESULT - 1);
    localparam logic [IDX_WIDTH-1:0]   IDX_ONE       = IDX_WIDTH'(1);

    state_t                 state;
    logic [TIMER_WIDTH-1:0] interval_tmr;
    logic [TIMER_WIDTH-1:0] interval_nxt;
    logic [TIMER_WIDTH-1:0] timeout_cnt;
    logic                   last_sample;
    logic                   last_period;

    assign interval_nxt = (interval_tmr == '0) ? '0 : interval_tmr - TIMER_ONE;
    assign last_sample  = (sample_index == SAMPLE_LAST);
    assign last_period  = (period_index == PERIOD_LAST);

    // NOTE: all state and outputs are updated with non-blocking assignments so every
    // branch sees the pre-edge values; later assignments in the block take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sample_req   <= 1'b0;
            period_first <= 1'b0;
            cycle_done   <= 1'b0;
            active       <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
            sample_index <= '0;
            period_index <= '0;
            interval_tmr <= '0;
            timeout_cnt  <= '0;
        end else begin
            sample_req   <= 1'b0;
            period_first <= 1'b0;
            cycle_done   <= 1'b0;

            // Clear first so a coincident set event below overrides it.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end

            if (!enable) begin
                state        <= IDLE;
                active       <= 1'b0;
                sample_index <= '0;
                period_index <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sample_index <= '0;
                        period_index <= '0;
                        if (cycle_start) begin
                            state        <= REQ;
                            active       <= 1'b1;
                            sample_req   <= 1'b1;
                            period_first <= 1'b1;
                        end
                    end

                    REQ: begin
                        state        <= WAIT_DONE;
                        interval_tmr <= INTERVAL_LOAD;
                        timeout_cnt  <= '0;
                    end

                    WAIT_DONE: begin
                        interval_tmr <= interval_nxt;
                        timeout_cnt  <= timeout_cnt + TIMER_ONE;
                        if (sample_done) begin
                            if (last_sample && last_period) begin
                                state      <= DONE;
                                cycle_done <= 1'b1;
                            end else begin
                                state <= GAP;
                                if (last_sample) begin
                                    sample_index <= '0;
                                    period_index <= period_index + IDX_ONE;
                                end else begin
                                    sample_index <= sample_index + IDX_ONE;
                                end
                            end
                        end else begin
                            if (interval_tmr == TIMER_ONE)
                                overrun <= 1'b1;
                            if (timeout_cnt == TIMEOUT_LAST) begin
                                timeout_err  <= 1'b1;
                                state        <= IDLE;
                                active       <= 1'b0;
                                sample_index <= '0;
                                period_index <= '0;
                            end
                        end
                    end

                    GAP: begin
                        interval_tmr <= interval_nxt;
                        // Issue the next request on the edge the interval expires, or
                        // immediately if a late sample_done left the timer already at 0.
                        if (interval_nxt == '0) begin
                            state        <= REQ;
                            sample_req   <= 1'b1;
                            period_first <= (sample_index == '0);
                        end
                    end

                    DONE: begin
                        state        <= IDLE;
                        active       <= 1'b0;
                        sample_index <= '0;
                        period_index <= '0;
                    end

                    default: begin
                        state        <= IDLE;
                        active       <= 1'b0;
                        sample_index <= '0;
                        period_index <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler with a modelled ADC reader and a
// scoreboard of expected sample_req / cycle_done events.
module tb_adc_conv_scheduler;

    localparam int SI  = 10;
    localparam int SPP = 4;
    localparam int PPR = 2;
    localparam int IW  = 6;
    localparam int TW  = 16;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          cycle_start = 1'b0;
    logic          sample_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          sample_req;
    logic          period_first;
    logic          cycle_done;
    logic          active;
    logic          overrun;
    logic          timeout_err;
    logic [IW-1:0] sample_index;
    logic [IW-1:0] period_index;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reader model configuration (written by stimulus) and state (written by reader).
    int rd_delay = 3;
    int late_req = -1;
    int late_d   = 0;
    int mute_req = -1;
    int stray_at = -1;
    int nreq     = 0;
    int done_at  = -1;

    typedef struct {
        int cyc;
        int sidx;
        int pidx;
        int first;
    } exp_req_t;

    exp_req_t req_q[$];
    int       done_q[$];
    exp_req_t mon_e;
    int       mon_d;

    adc_conv_scheduler #(
        .SAMPLE_INTERVAL   (SI),
        .SAMPLES_PER_PERIOD(SPP),
        .PERIODS_PER_RESULT(PPR),
        .IDX_WIDTH         (IW),
        .TIMER_WIDTH       (TW),
        .TIMEOUT_CLKS      (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cycle_start (cycle_start),
        .sample_req  (sample_req),
        .sample_done (sample_done),
        .sample_index(sample_index),
        .period_index(period_index),
        .period_first(period_first),
        .cycle_done  (cycle_done),
        .active      (active),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reader: answers each request so sample_done is sampled d edges after the
    // request edge. Monitor: pops the scoreboard on each DUT output event.
    always @(negedge clk) begin
        sample_done = (cyc == done_at) || (cyc == stray_at);
        if (!rst && sample_req) begin
            nreq = nreq + 1;
            if (nreq == late_req)
                done_at = cyc + late_d - 1;
            else if (nreq != mute_req)
                done_at = cyc + rd_delay - 1;
            check("req_expected", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
                mon_e = req_q.pop_front();
                check("req_cyc", cyc, mon_e.cyc);
                check("req_sidx", sample_index, mon_e.sidx);
                check("req_pidx", period_index, mon_e.pidx);
                check("req_first", period_first, mon_e.first);
            end
        end
        if (!rst && cycle_done) begin
            check("done_expected", done_q.size() != 0, 1);
            if (done_q.size() != 0) begin
                mon_d = done_q.pop_front();
                check("done_cyc", cyc, mon_d);
                check("done_sidx", sample_index, SPP - 1);
                check("done_pidx", period_index, PPR - 1);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulses cycle_start and queues the n expected requests: the next request
    // follows at the later of SI clocks or one clock after the GAP entry.
    task automatic start_cycle(input int n, input int late_i, input int ld, output int s);
        int r;
        int d;
        s           = cyc;
        cycle_start = 1'b1;
        late_req    = (late_i >= 0) ? nreq + late_i + 1 : -1;
        late_d      = ld;
        r           = s + 1;
        for (int i = 0; i < n; i++) begin
            exp_req_t e;
            e.cyc   = r;
            e.sidx  = i % SPP;
            e.pidx  = i / SPP;
            e.first = (i % SPP == 0) ? 1 : 0;
            req_q.push_back(e);
            d = (i == late_i) ? ld : rd_delay;
            if (i == SPP * PPR - 1)
                done_q.push_back(r + d);
            r = (SI > d + 1) ? r + SI : r + d + 1;
        end
        @(negedge clk);
        cycle_start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_q"}, req_q.size(), 0);
        check({tag, "_done_q"}, done_q.size(), 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_sidx"}, sample_index, 0);
        check({tag, "_pidx"}, period_index, 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        int s;
        int s2;

        // Reset state
        @(negedge clk);
        check("rst_req", sample_req, 0);
        check("rst_first", period_first, 0);
        check("rst_cdone", cycle_done, 0);
        check("rst_active", active, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_sidx", sample_index, 0);
        check("rst_pidx", period_index, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("idle_after_rst");

        // Nominal cycle: 8 requests 10 clocks apart
        start_cycle(8, -1, 0, s);
        wait_cyc(s + 80);
        check_idle("nominal");
        check("nominal_overrun", overrun, 0);

        // Late answer to 3rd request: overrun and stretched spacing
        start_cycle(8, 2, 14, s);
        wait_cyc(s + 30);
        check("late_overrun_before", overrun, 0);
        wait_cyc(s + 31);
        check("late_overrun_set", overrun, 1);
        wait_cyc(s + 90);
        check_idle("late");
        check("late_overrun_sticky", overrun, 1);
        pulse_err_clr();
        check("late_overrun_clr", overrun, 0);

        // Reader never answers 2nd request
        mute_req = nreq + 2;
        start_cycle(2, -1, 0, s);
        wait_cyc(s + 30);
        check("to_before", timeout_err, 0);
        check("to_active_before", active, 1);
        wait_cyc(s + 31);
        check("to_set", timeout_err, 1);
        check("to_active_after", active, 0);
        check("to_sidx", sample_index, 0);
        wait_cyc(s + 40);
        check_idle("to");
        mute_req = -1;
        start_cycle(8, -1, 0, s2);
        wait_cyc(s2 + 80);
        check_idle("to_restart");
        check("to_sticky", timeout_err, 1);
        pulse_err_clr();
        check("to_clr", timeout_err, 0);

        // enable dropped while waiting for the 5th sample
        start_cycle(5, -1, 0, s);
        wait_cyc(s + 42);
        check("en_active", active, 1);
        check("en_pidx", period_index, 1);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_active", active, 0);
        check("en_drop_sidx", sample_index, 0);
        check("en_drop_pidx", period_index, 0);
        enable = 1'b1;
        wait_cyc(s + 60);
        check_idle("en");

        // cycle_start and sample_done pulsed in GAP are ignored
        stray_at = cyc + 25;
        start_cycle(8, -1, 0, s);
        wait_cyc(s + 16);
        cycle_start = 1'b1;
        @(negedge clk);
        cycle_start = 1'b0;
        wait_cyc(s + 80);
        check_idle("gap_noise");
        stray_at = -1;

        // Async reset between edges while waiting for a sample
        start_cycle(1, -1, 0, s);
        wait_cyc(s + 2);
        check("arst_active_before", active, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", sample_req, 0);
        check("arst_first", period_first, 0);
        check("arst_cdone", cycle_done, 0);
        check("arst_active", active, 0);
        check("arst_overrun", overrun, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_sidx", sample_index, 0);
        check("arst_pidx", period_index, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_idle("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_conv_scheduler.md
Name: adc_conv_scheduler

Overview:
- Sequences the ADC acquisition path for one measurement cycle: paced single-cycle sample requests to the ADC sample reader (CNV + SPI readout), PERIODS_PER_RESULT periods of SAMPLES_PER_PERIOD samples each.
- Tracks sample/period indices for downstream integration; flags result completion, pacing overruns and reader timeouts.
- Sits between the cycle-control logic and the ADC read block.

Parameters:
- SAMPLE_INTERVAL, 1000: clocks between successive sample_req pulses (min 2).
- SAMPLES_PER_PERIOD, 32: samples per period (min 1).
- PERIODS_PER_RESULT, 32: periods per result cycle (min 1).
- IDX_WIDTH, 6: width of sample_index and period_index; must hold 0..N-1 of both counts.
- TIMER_WIDTH, 16: width of interval and timeout counters.
- TIMEOUT_CLKS, 4000: max clocks from sample_req to sample_done before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  level; 0 forces IDLE at next edge, drops any in-flight sample
- cycle_start  in  1  single-cycle pulse; starts a result cycle when IDLE
- sample_req  out  1  single-cycle pulse to ADC reader: start one conversion+readout
- sample_done  in  1  single-cycle pulse from reader: sample data valid
- sample_index  out  IDX_WIDTH  index of outstanding/last sample within period
- period_index  out  IDX_WIDTH  current period index
- period_first  out  1  high with sample_req when sample_index==0
- cycle_done  out  1  single-cycle pulse after last sample_done of cycle
- active  out  1  high in every state except IDLE
- overrun  out  1  sticky: interval expired while sample outstanding
- timeout_err  out  1  sticky: TIMEOUT_CLKS exceeded
- err_clr  in  1  single-cycle; clears overrun and timeout_err

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters and timers 0.
- States: IDLE, REQ, WAIT_DONE, GAP, DONE.
- IDLE: on cycle_start & enable -> REQ next clock. Indices cleared to 0. cycle_start outside IDLE ignored.
- REQ (1 clock): sample_req=1, period_first=(sample_index==0). Interval timer loads SAMPLE_INTERVAL-1; timeout counter loads 0. -> WAIT_DONE.
- Interval timer decrements each clock in WAIT_DONE/GAP, saturating at 0.
- Timeout counter increments each clock in WAIT_DONE.
- WAIT_DONE on sample_done:
  - If sample_index==SAMPLES_PER_PERIOD-1 and period_index==PERIODS_PER_RESULT-1 -> DONE.
  - Else advance indices: sample_index wraps to 0 and period_index++ at period end. -> GAP.
- WAIT_DONE while interval timer at 0 and no sample_done: set overrun once; continue waiting.
- WAIT_DONE, timeout counter reaches TIMEOUT_CLKS without sample_done: set timeout_err -> IDLE, indices cleared, no cycle_done.
- GAP: when interval timer==0 -> REQ.
  - Late sample_done after interval expiry: GAP with timer already 0 -> REQ on next clock. Spacing stretches; never two reqs outstanding.
- Nominal spacing: exactly SAMPLE_INTERVAL clocks between sample_req rising edges when sample_done arrives at least 2 clocks before expiry.
- DONE (1 clock): cycle_done=1; indices hold final values -> IDLE.
- sample_done outside WAIT_DONE ignored.
- sample_done coinciding with the timeout cycle: sample_done wins; no timeout_err.
- enable=0 in any state: -> IDLE next clock, indices cleared, no cycle_done, sticky flags kept.
- err_clr coincident with a new set event: set wins.
- Latency:
  - cycle_start to first sample_req: 1 clock.
  - Last sample_done to cycle_done: 1 clock.
- Widths: parameter comparisons use TIMER_WIDTH/IDX_WIDTH truncation.

Test Plan:
- SAMPLE_INTERVAL=10, SAMPLES_PER_PERIOD=4, PERIODS_PER_RESULT=2; reader answers 3 clocks after each req; pulse cycle_start -> 8 sample_req pulses exactly 10 clocks apart; period_first on 1st and 5th; cycle_done 1 clock after 8th sample_done; overrun=0.
- Same config, reader answers 14 clocks after 3rd req -> overrun=1 at clock 10 after that req; 4th req 1 clock after GAP entry (15 clocks after 3rd); cycle completes; err_clr clears overrun.
- TIMEOUT_CLKS=20, reader never answers 2nd req -> timeout_err=1 at 20 clocks after req; active=0 next clock; no cycle_done; new cycle_start restarts from index 0.
- enable dropped in WAIT_DONE of 5th sample -> IDLE next clock; subsequent sample_done ignored; indices 0.
- cycle_start pulsed mid-cycle and sample_done pulsed in GAP -> no extra sample_req; sequence timing unchanged.
- Async rst asserted mid-WAIT_DONE between clock edges -> all outputs 0 immediately; after release, idle until cycle_start.
